timer_sched: RTL and testbench

Multi-channel timeout scheduler that owns the memory-mapped timer block and shares it among `NCH` software-visible channels. After reset it programs the timer through the timer's register bus as a free-running periodic tick source with period `PRESCALE` clocks, discards the priming pulse, then uses each `timeout` pulse as a tick. Each channel holds an independent down-counter in ticks and raises an expiry pulse plus a sticky pending bit. It sits between the CPU-side event logic and the timer, and is the only master on the timer's `sel`/`we`/`addr`/`wdata` bus.

---
 rtl/timer_sched_if.sv | 43 ++++
 rtl/timer_sched.sv | 166 ++++++++++++++++
 tb/tb_timer_sched.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_sched_if.sv
// Port bundle for timer_sched: the CPU-side arm/cancel/ack/expiry signals and
// the register bus that programs the shared timer.
interface timer_sched_if #(
    parameter int NCH = 4,
    parameter int CW  = 16
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    // Arm handshake: arm_valid may be raised at any time and its payload
    // (arm_ch/arm_ticks/arm_periodic) is only meaningful while it is high. The
    // request is consumed on the rising clk edge where arm_valid & arm_ready.
    // arm_ready never depends on arm_valid.
    logic           arm_valid;
    logic           arm_ready;
    logic [CHW-1:0] arm_ch;
    logic [CW-1:0]  arm_ticks;
    logic           arm_periodic;

    logic [NCH-1:0] cancel;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] expire;
    logic [NCH-1:0] pending;
    logic           irq;
    logic [NCH-1:0] active;

    logic           t_sel;
    logic           t_we;
    logic [31:0]    t_addr;
    logic [31:0]    t_wdata;
    logic           t_timeout;

    // The scheduler itself.
    modport slave (
        input  arm_valid, arm_ch, arm_ticks, arm_periodic, cancel, ack, t_timeout,
        output arm_ready, expire, pending, irq, active, t_sel, t_we, t_addr, t_wdata
    );

    // The surroundings: CPU event logic plus the timer peripheral.
    modport master (
        output arm_valid, arm_ch, arm_ticks, arm_periodic, cancel, ack, t_timeout,
        input  arm_ready, expire, pending, irq, active, t_sel, t_we, t_addr, t_wdata
    );
endinterface

// File: rtl/timer_sched.sv
// Multi-channel timeout scheduler driving a shared periodic timer tick.
// Optional feature macro: TSCHED_PERIODIC_EN (periodic reload per channel).
module timer_sched #(
    parameter int NCH      = 4,
    parameter int CW       = 16,
    parameter int PRESCALE = 100
) (
    input  logic        clk,
    input  logic        resetn,
    timer_sched_if.slave bus,
    output logic [1:0]  state_o
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] ST_INIT_LOAD = 2'd0;
    localparam logic [1:0] ST_INIT_CTRL = 2'd1;
    localparam logic [1:0] ST_PRIME     = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
    localparam logic [31:0] ADDR_LOAD   = 32'h0000_0004;
    localparam logic [31:0] CTRL_EN_PER = 32'h0000_0003;
    localparam logic [31:0] LOAD_VAL    = 32'(PRESCALE - 1);

    logic [1:0]     state_q, state_d;
    logic           started_q;
    logic           run;
    logic           tick;
    logic           arm_fire;
    logic [CW-1:0]  arm_len;

    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] active_q, active_d;
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] expire_q, expire_d;

`ifdef TSCHED_PERIODIC_EN
    logic [NCH-1:0] per_q, per_d;
    logic [CW-1:0]  reload_q [NCH];
    logic [CW-1:0]  reload_d [NCH];
`else
    logic unused_periodic;
    assign unused_periodic = bus.arm_periodic;
`endif

    assign run      = (state_q == ST_RUN);
    assign tick     = run & bus.t_timeout;
    assign arm_fire = run & bus.arm_valid;
    assign arm_len  = (bus.arm_ticks == '0) ? CW'(1) : bus.arm_ticks;

    // started_q holds INIT_LOAD off the bus during reset so every output is 0
    // until the first edge after release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT_LOAD: if (started_q) state_d = ST_INIT_CTRL;
            ST_INIT_CTRL: state_d = ST_PRIME;
            ST_PRIME:     if (bus.t_timeout) state_d = ST_RUN;
            default:      state_d = state_q;
        endcase
    end

    always_comb begin
        bus.t_sel   = 1'b0;
        bus.t_we    = 1'b0;
        bus.t_addr  = '0;
        bus.t_wdata = '0;
        if (started_q) begin
            case (state_q)
                ST_INIT_LOAD: begin
                    bus.t_sel   = 1'b1;
                    bus.t_we    = 1'b1;
                    bus.t_addr  = ADDR_LOAD;
                    bus.t_wdata = LOAD_VAL;
                end
                ST_INIT_CTRL: begin
                    bus.t_sel   = 1'b1;
                    bus.t_we    = 1'b1;
                    bus.t_addr  = ADDR_CTRL;
                    bus.t_wdata = CTRL_EN_PER;
                end
                default: ;
            endcase
        end
    end

    // Per-channel priority: arm, then cancel, then the tick; a pending set
    // overrides a same-cycle ack.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
`ifdef TSCHED_PERIODIC_EN
            reload_d[i] = reload_q[i];
`endif
        end
`ifdef TSCHED_PERIODIC_EN
        per_d = per_q;
`endif
        active_d  = active_q;
        expire_d  = '0;
        pending_d = pending_q & ~(run ? bus.ack : '0);
        for (int i = 0; i < NCH; i++) begin
            if (arm_fire && (bus.arm_ch == CHW'(i))) begin
                cnt_d[i]    = arm_len;
                active_d[i] = 1'b1;
`ifdef TSCHED_PERIODIC_EN
                per_d[i]    = bus.arm_periodic;
                reload_d[i] = arm_len;
`endif
            end else if (run && bus.cancel[i]) begin
                active_d[i] = 1'b0;
            end else if (tick && active_q[i]) begin
                if (cnt_q[i] > CW'(1)) begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end else begin
                    expire_d[i]  = 1'b1;
                    pending_d[i] = 1'b1;
`ifdef TSCHED_PERIODIC_EN
                    if (per_q[i]) cnt_d[i] = reload_q[i];
                    else          active_d[i] = 1'b0;
`else
                    active_d[i] = 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_INIT_LOAD;
            started_q <= 1'b0;
            active_q  <= '0;
            pending_q <= '0;
            expire_q  <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            active_q  <= active_d;
            pending_q <= pending_d;
            expire_q  <= expire_d;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef TSCHED_PERIODIC_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            per_q <= '0;
            for (int i = 0; i < NCH; i++) reload_q[i] <= '0;
        end else begin
            per_q <= per_d;
            for (int i = 0; i < NCH; i++) reload_q[i] <= reload_d[i];
        end
    end
`endif

    assign bus.arm_ready = run;
    assign bus.expire    = expire_q;
    assign bus.pending   = pending_q;
    assign bus.active    = active_q;
    assign bus.irq       = |pending_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: timer peripheral model, deadline-based reference
// model, expiry scoreboard and per-cycle status checks.
module tb_timer_sched;
  localparam int NCH = 4;
  localparam int CW = 16;
  localparam int PRESCALE = 20;
  localparam int CHW = $clog2(NCH);
  localparam int W = 32 + NCH;
`ifdef TSCHED_PERIODIC_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [1:0] state;

  timer_sched_if #(.NCH(NCH), .CW(CW)) bus ();

  timer_sched #(.NCH(NCH), .CW(CW), .PRESCALE(PRESCALE)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .state_o(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int cyc;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- timer peripheral model ----------------
  logic [31:0] tm_load;
  logic tm_en;
  logic [31:0] tm_cnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tm_load <= 32'd0;
      tm_en <= 1'b0;
      tm_cnt <= 32'd0;
      bus.t_timeout <= 1'b0;
    end else begin
      if (bus.t_sel && bus.t_we && bus.t_addr == 32'h4) tm_load <= bus.t_wdata;
      bus.t_timeout <= tm_en && (tm_cnt == 32'd0);
      if (tm_en) tm_cnt <= (tm_cnt == 32'd0) ? tm_load : tm_cnt - 32'd1;
      if (bus.t_sel && bus.t_we && bus.t_addr == 32'h0) begin
        tm_en <= bus.t_wdata[0];
        tm_cnt <= 32'd0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Each channel keeps an absolute deadline in ticks; it expires when the tick
  // count reaches it.
  bit m_run;
  int m_tick;
  bit m_act[NCH];
  int m_dead[NCH];
  int m_per[NCH];
  bit [NCH-1:0] m_pend;
  bit [NCH-1:0] m_ev;
  bit m_tk;
  int m_n;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_run = 1'b0;
      m_tick = 0;
      m_pend = '0;
      cyc = 0;
      for (int i = 0; i < NCH; i++) m_act[i] = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      m_tk = m_run && bus.t_timeout;
      if (m_tk) m_tick++;
      m_ev = '0;
      m_n = (bus.arm_ticks == '0) ? 1 : int'(bus.arm_ticks);
      for (int i = 0; i < NCH; i++) begin
        if (m_run && bus.arm_valid && int'(bus.arm_ch) == i) begin
          m_act[i] = 1'b1;
          m_dead[i] = m_tick + m_n;
          m_per[i] = (PER_EN && bus.arm_periodic) ? m_n : 0;
        end else if (m_run && bus.cancel[i]) begin
          m_act[i] = 1'b0;
        end else if (m_tk && m_act[i] && m_dead[i] == m_tick) begin
          m_ev[i] = 1'b1;
          if (m_per[i] != 0) m_dead[i] = m_dead[i] + m_per[i];
          else m_act[i] = 1'b0;
        end
        if (m_run && bus.ack[i]) m_pend[i] = 1'b0;
        if (m_ev[i]) m_pend[i] = 1'b1;
      end
      if (m_ev != '0) exp_q.push_back({32'(cyc), m_ev});
      if (!m_run && bus.t_timeout) m_run = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] mon_e;
  logic [NCH-1:0] mon_act;
  always @(negedge clk) begin
    if (resetn) begin
      while (exp_q.size() > 0 && exp_q[0][W-1:NCH] < 32'(cyc)) begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL expire_missing: got none required %b at cycle %0d", mon_e[NCH-1:0], mon_e[W-1:NCH]);
      end
      if (bus.expire != '0 || (exp_q.size() > 0 && exp_q[0][W-1:NCH] == 32'(cyc))) begin
        mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("expire", {32'(cyc), bus.expire}, mon_e);
      end
      for (int i = 0; i < NCH; i++) mon_act[i] = m_act[i];
      check("pending", bus.pending, m_pend);
      check("active", bus.active, mon_act);
      check("irq", bus.irq, |m_pend);
      check("arm_ready", bus.arm_ready, m_run);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.arm_valid = 1'b0;
    bus.arm_ch = '0;
    bus.arm_ticks = '0;
    bus.arm_periodic = 1'b0;
    bus.cancel = '0;
    bus.ack = '0;
  endtask

  // Holds the given inputs for exactly one cycle; called #1 after a posedge.
  task automatic drive(input bit av, input int ch, input int tk, input bit per,
                       input logic [NCH-1:0] cn, input logic [NCH-1:0] ak);
    bus.arm_valid = av;
    bus.arm_ch = CHW'(ch);
    bus.arm_ticks = CW'(tk);
    bus.arm_periodic = per;
    bus.cancel = cn;
    bus.ack = ak;
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, '0, '0);
  endtask

  // Returns inside the n-th tick cycle counted from the current one.
  task automatic wait_ticks(input int n);
    int k = 0;
    int b = 0;
    forever begin
      if (bus.t_timeout) k++;
      if (k >= n) return;
      @(posedge clk);
      #1;
      b++;
      if (b > (n + 2) * PRESCALE) begin
        n_cmp++;
        n_err++;
        $display("FAIL tick_wait: got %0d ticks required %0d", k, n);
        return;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_expire"}, bus.expire, 0);
    check({tag, "_pending"}, bus.pending, 0);
    check({tag, "_active"}, bus.active, 0);
    check({tag, "_irq"}, bus.irq, 0);
    check({tag, "_arm_ready"}, bus.arm_ready, 0);
    check({tag, "_t_sel"}, bus.t_sel, 0);
    check({tag, "_t_we"}, bus.t_we, 0);
    check({tag, "_t_addr"}, bus.t_addr, 0);
    check({tag, "_t_wdata"}, bus.t_wdata, 0);
    check({tag, "_state"}, state, 0);
  endtask

  task automatic release_and_init();
    int b;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("init_load_sel", {bus.t_sel, bus.t_we}, 2'b11);
    check("init_load_addr", bus.t_addr, 32'h4);
    check("init_load_data", bus.t_wdata, 32'(PRESCALE - 1));
    @(negedge clk);
    check("init_ctrl_sel", {bus.t_sel, bus.t_we}, 2'b11);
    check("init_ctrl_addr", bus.t_addr, 32'h0);
    check("init_ctrl_data", bus.t_wdata, 32'h3);
    @(negedge clk);
    check("prime_bus_idle", {bus.t_sel, bus.t_we}, 2'b00);
    check("prime_not_ready", bus.arm_ready, 0);
    b = 0;
    while (!bus.arm_ready && b < 4 * PRESCALE) begin
      @(negedge clk);
      b++;
    end
    check("ready_reached", bus.arm_ready, 1);
    check("run_bus_idle", {bus.t_sel, bus.t_we, bus.t_addr, bus.t_wdata}, 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    release_and_init();

    // one-shot, then ack
    drive(1'b1, 0, 3, 1'b0, '0, '0);
    wait_ticks(3);
    step(3);
    drive(1'b0, 0, 0, 1'b0, '0, 4'b0001);
    step(2);

    // two channels armed back to back expire together
    wait_ticks(1);
    drive(1'b1, 1, 2, 1'b0, '0, '0);
    drive(1'b1, 2, 2, 1'b0, '0, '0);
    wait_ticks(2);
    step(2);
    drive(1'b0, 0, 0, 1'b0, '0, 4'b0110);

    // cancel on the expiring tick
    drive(1'b1, 3, 5, 1'b0, '0, '0);
    wait_ticks(5);
    drive(1'b0, 0, 0, 1'b0, 4'b1000, '0);
    step(PRESCALE);

    // re-arm on the expiring tick
    drive(1'b1, 3, 5, 1'b0, '0, '0);
    wait_ticks(5);
    drive(1'b1, 3, 4, 1'b0, '0, '0);
    wait_ticks(4);
    step(3);
    drive(1'b0, 0, 0, 1'b0, '0, 4'b1000);

    // periodic channel (one-shot when the feature is built out); zero ticks
    drive(1'b1, 0, 2, 1'b1, '0, '0);
    wait_ticks(7);
    drive(1'b0, 0, 0, 1'b0, 4'b0001, '0);
    drive(1'b1, 1, 0, 1'b0, '0, '0);
    step(3 * PRESCALE);
    drive(1'b0, 0, 0, 1'b0, '0, 4'b1111);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 11) == 0, $urandom_range(0, NCH - 1), $urandom_range(0, 6),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0) ? NCH'($urandom_range(0, (1 << NCH) - 1)) : '0,
            ($urandom_range(0, 7) == 0) ? NCH'($urandom_range(0, (1 << NCH) - 1)) : '0);
    end

    // reset while channels are counting
    drive(1'b1, 0, 3, 1'b0, '0, '0);
    drive(1'b1, 1, 2, 1'b1, '0, '0);
    wait_ticks(2);
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    release_and_init();
    step(4 * PRESCALE);
    drive(1'b1, 2, 1, 1'b0, '0, '0);
    wait_ticks(1);
    step(2);

    // quiesce and drain
    drive(1'b0, 0, 0, 1'b0, '1, '1);
    step(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d expiries outstanding required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end
endmodule
